lane_traffic_engine: RTL
========================

LANE_TRAFFIC_ENGINE -- requirements
Module: lane_traffic_engine

Interface
REQ-001 SHALL have parameter N_LANES, default 10, number of car lanes.
REQ-002 SHALL have parameter POS_W, default 5, tile-position counter width; tile = 32 px.
REQ-003 SHALL have parameter SPD_W, default 4, width of per-lane speed and tick counters.
REQ-004 SHALL have parameter MAX_LEVEL, default 8, last level before wrap to 0.
REQ-005 SHALL have parameter HOLD_TICKS, default 16, freeze length after a death or win, in clk_enable ticks.
REQ-006 SHALL have port clk, input, 1, system clock.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port clk_enable, input, 1, one-cycle game tick from the clock divider.
REQ-009 SHALL have port frog_x, input, 10, frog pixel X.
REQ-010 SHALL have port frog_y, input, 10, frog pixel Y.
REQ-011 SHALL have port lane_y, input, N_LANES*10, packed per-lane pixel Y.
REQ-012 SHALL have port lane_dir, input, N_LANES, per-lane direction: 0 = right, 1 = left.
REQ-013 SHALL have port lane_len, input, N_LANES*2, per-lane car length in tiles (1-3).
REQ-014 SHALL have port lane_speed, input, N_LANES*SPD_W, per-lane base tick period.
REQ-015 SHALL have port car_x, output, N_LANES*10, packed car pixel X = pos*32.
REQ-016 SHALL have port level, output, 4, current level.
REQ-017 SHALL have port frog_reset, output, 1, one-cycle pulse that returns the frog to its start position.
REQ-018 SHALL have port death_pulse, output, 1, one-cycle pulse on collision.
REQ-019 SHALL have port win_pulse, output, 1, one-cycle pulse on reaching frog_y == 0.
REQ-020 SHALL have port lives, output, 2, remaining lives.
REQ-021 SHALL have port frozen, output, 1, high while the state is not PLAY.

Function
REQ-022 SHALL implement the states PLAY, HIT and WON.
- PLAY -> HIT on death.
- PLAY -> WON on win.
- HIT or WON -> PLAY after HOLD_TICKS clk_enable ticks.
REQ-023 SHALL, per lane, count clk_enable ticks only in PLAY; when count >= period, step pos by one tile and clear count.
REQ-024 SHALL compute period = lane_speed - level, saturated to a minimum of 1.
REQ-025 SHALL wrap pos 2^POS_W-1 -> 0 when dir=0, and 0 -> 2^POS_W-1 when dir=1.
REQ-026 SHALL detect death (combinational, 11-bit arithmetic, no wrap-around handling) when all of the following hold for any lane:
- frog_y == lane_y;
- frog_x + 32 > car_x;
- frog_x < car_x + len*32.
REQ-027 SHALL detect win when frog_y == 0; death has priority if both occur in the same cycle.
REQ-028 SHALL evaluate death and win only in PLAY.
REQ-029 SHALL assert death_pulse or win_pulse, plus frog_reset, for exactly one cycle on the PLAY exit transition.
REQ-030 SHALL, on win, set level <= (level < MAX_LEVEL) ? level+1 : 0.
REQ-031 SHALL return all lane positions and tick counts to 0 on PLAY exit, so every lane restarts at x = 0.
REQ-032 SHALL register car_x, with latency one clk after a pos update.
REQ-033 SHALL, if clk_enable is high on the cycle the HOLD_TICKS count completes, enter PLAY without stepping any lane that cycle.

Reset
REQ-034 SHALL asynchronously force, while reset_n is low: state=PLAY, level=0, all pos and counters=0, car_x=0, pulses=0, frozen=0, lives=3 (0 without the macro).
REQ-035 SHALL abandon a reset asserted mid-HIT or mid-WON with no pending pulse, and resume in PLAY after release.

Configuration
REQ-036 SHALL support the macro GAME_LIVES_EN. With it defined, each death decrements lives. When lives reaches 0 (death with lives==1), level is cleared to 0 and lives reloads to 3; otherwise level is unchanged.
REQ-037 SHALL, without GAME_LIVES_EN, clear level to 0 on every death and tie lives to 0.

Structure
REQ-038 SHALL place the state encoding, TILE_PX=32, LIVES_INIT=3 and the screen Y of the goal row in the shared package frogger_pkg.
REQ-039 SHALL use one sub-module, lane_mover (tick counter, position, wrap, car_x register), instantiated N_LANES times in a generate loop; FSM, level, lives and collision logic stay in the top.

Verification
REQ-040 SHALL cover lane0 speed=12, level=0, dir=0: 12 clk_enable ticks -> pos 0->1, car_x=32.
REQ-041 SHALL cover dir=1 from pos 0: one step -> pos=31, car_x=992; dir=0 from pos 31: one step -> pos 0.
REQ-042 SHALL cover frog_x=40, frog_y=lane_y, car_x=32, len=1: death_pulse one cycle, frog_reset one cycle, frozen for 16 ticks, cars held.
REQ-043 SHALL cover level=8 and frog_y=0: win_pulse, level -> 0; level=3 and frog_y=0: level -> 4; lane speed=2 at level 4 gives period 1.
REQ-044 SHALL cover death and win asserted in the same cycle: only death_pulse fires, and level follows the death rule.
REQ-045 SHALL cover, with GAME_LIVES_EN and level=5: deaths 1 and 2 leave level=5 with lives 2 then 1; death 3 gives level=0, lives=3. The bench SHALL also pulse reset_n low mid-HIT -> state PLAY, no pulses.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared constants for the lane traffic engine: FSM encoding, tile size, lives, goal row,
// plus the frog/car overlap test used by the collision logic.
package frogger_pkg;

  localparam logic [1:0] StPlay = 2'd0;
  localparam logic [1:0] StHit  = 2'd1;
  localparam logic [1:0] StWon  = 2'd2;

  localparam int unsigned TILE_PX    = 32;
  localparam logic [1:0]  LIVES_INIT = 2'd3;
  localparam logic [9:0]  GOAL_Y     = 10'd0;

  // Frog is one tile wide; car spans len tiles. 11-bit sums, no screen wrap handling.
  function automatic logic car_hit(input logic [9:0] fx, input logic [9:0] fy,
                                   input logic [9:0] ly, input logic [9:0] cx,
                                   input logic [1:0] len);
    logic [10:0] frog_r;
    logic [10:0] car_r;
    frog_r = {1'b0, fx} + 11'(TILE_PX);
    car_r  = {1'b0, cx} + 11'(len) * 11'(TILE_PX);
    return (fy == ly) && (frog_r > {1'b0, cx}) && ({1'b0, fx} < car_r);
  endfunction

endpackage

// File: rtl/lane_mover.sv
// One car lane: tick counter against a level-adjusted period, wrapping tile position,
// and the registered pixel X of the car.
module lane_mover
  import frogger_pkg::*;
#(
  parameter int unsigned POS_W = 5,
  parameter int unsigned SPD_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             clear,
  input  logic             dir,
  input  logic [SPD_W-1:0] speed,
  input  logic [3:0]       level,
  output logic [9:0]       car_x
);

  localparam int unsigned CW = ((SPD_W > 4) ? SPD_W : 4) + 1;

  logic [POS_W-1:0] pos_q, pos_d;
  logic [SPD_W-1:0] cnt_q, cnt_d;
  logic [9:0]       car_x_q, car_x_d;
  logic [CW-1:0]    period;
  logic [CW-1:0]    cnt_inc;

  always_comb begin
    // Faster at higher levels, but never faster than one step per tick.
    period  = (CW'(speed) > CW'(level)) ? CW'(speed) - CW'(level) : CW'(1);
    cnt_inc = CW'(cnt_q) + CW'(1);
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    if (clear) begin
      pos_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_inc >= period) begin
        cnt_d = '0;
        pos_d = dir ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
      end else begin
        cnt_d = SPD_W'(cnt_inc);
      end
    end
    car_x_d = 10'(32'(pos_q) * TILE_PX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q   <= '0;
      cnt_q   <= '0;
      car_x_q <= '0;
    end else begin
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      car_x_q <= car_x_d;
    end
  end

  assign car_x = car_x_q;

endmodule

// File: rtl/lane_traffic_engine.sv
// Frogger lane engine: PLAY/HIT/WON state machine, level and lives tracking, collision.
// Define GAME_LIVES_EN to enable the three-lives scheme; otherwise every death resets level.
module lane_traffic_engine
  import frogger_pkg::*;
#(
  parameter int unsigned N_LANES    = 10,
  parameter int unsigned POS_W      = 5,
  parameter int unsigned SPD_W      = 4,
  parameter int unsigned MAX_LEVEL  = 8,
  parameter int unsigned HOLD_TICKS = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clk_enable,
  input  logic [9:0]               frog_x,
  input  logic [9:0]               frog_y,
  input  logic [N_LANES*10-1:0]    lane_y,
  input  logic [N_LANES-1:0]       lane_dir,
  input  logic [N_LANES*2-1:0]     lane_len,
  input  logic [N_LANES*SPD_W-1:0] lane_speed,
  output logic [N_LANES*10-1:0]    car_x,
  output logic [3:0]               level,
  output logic                     frog_reset,
  output logic                     death_pulse,
  output logic                     win_pulse,
  output logic [1:0]               lives,
  output logic                     frozen
);

  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
`ifdef GAME_LIVES_EN
  localparam logic [1:0] LivesRst = LIVES_INIT;
`else
  localparam logic [1:0] LivesRst = 2'd0;
`endif

  logic [1:0]         state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [3:0]         level_q, level_d;
  logic [1:0]         lives_q, lives_d;
  logic               death_q, win_q, frog_reset_q;
  logic               play, death, win, lane_tick, lane_clear;
  logic [N_LANES-1:0] lane_hit;

  assign play       = (state_q == StPlay);
  assign lane_tick  = play & clk_enable;
  assign lane_clear = death | win;

  always_comb begin
    lane_hit = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      lane_hit[i] = car_hit(frog_x, frog_y, lane_y[i*10 +: 10], car_x[i*10 +: 10],
                            lane_len[i*2 +: 2]);
    end
  end

  assign death = play & (|lane_hit);
  assign win   = play & (frog_y == GOAL_Y) & ~death;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    level_d = level_q;
    lives_d = lives_q;
    case (state_q)
      StPlay: begin
        if (death) begin
          state_d = StHit;
          hold_d  = '0;
`ifdef GAME_LIVES_EN
          if (lives_q == 2'd1) begin
            level_d = '0;
            lives_d = LIVES_INIT;
          end else begin
            lives_d = lives_q - 2'd1;
          end
`else
          level_d = '0;
`endif
        end else if (win) begin
          state_d = StWon;
          hold_d  = '0;
          level_d = (level_q < 4'(MAX_LEVEL)) ? level_q + 4'd1 : 4'd0;
        end
      end
      StHit, StWon: begin
        if (clk_enable) begin
          if (32'(hold_q) + 32'd1 >= HOLD_TICKS) begin
            state_d = StPlay;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StPlay;
      hold_q       <= '0;
      level_q      <= '0;
      lives_q      <= LivesRst;
      death_q      <= 1'b0;
      win_q        <= 1'b0;
      frog_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      death_q      <= death;
      win_q        <= win;
      frog_reset_q <= death | win;
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    lane_mover #(
      .POS_W(POS_W),
      .SPD_W(SPD_W)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (lane_tick),
      .clear  (lane_clear),
      .dir    (lane_dir[g]),
      .speed  (lane_speed[g*SPD_W +: SPD_W]),
      .level  (level_q),
      .car_x  (car_x[g*10 +: 10])
    );
  end

  assign level       = level_q;
  assign lives       = lives_q;
  assign death_pulse = death_q;
  assign win_pulse   = win_q;
  assign frog_reset  = frog_reset_q;
  assign frozen      = ~play;

endmodule
